// File: rtl/key_conditioner.sv
// Board-button conditioner: synchronizes and debounces six raw keys, emits one-cycle
// press pulses, and auto-repeats the four direction keys with opposing-pair suppression.
module key_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_enter,
  input  logic       btn_pause,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic       enter,
  output logic       pause,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right,
  output logic [5:0] key_level
);

  localparam int          NumKeys = 6;
  localparam int          NumDirs = 4;
  localparam int unsigned DbW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RepMax  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RepW    = (RepMax > 1) ? $clog2(RepMax) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } repState_t;

  logic [NumKeys-1:0] rawKeys;
  logic [NumKeys-1:0] syncA;
  logic [NumKeys-1:0] syncB;
  logic [NumKeys-1:0] level;
  logic [NumKeys-1:0] levelNextC;
  logic [NumKeys-1:0] riseC;
  logic [NumDirs-1:0] dirPulseC;
  logic               upDownBlockC;
  logic               leftRightBlockC;

  assign rawKeys = {btn_right, btn_left, btn_down, btn_up, btn_pause, btn_enter};

  // Two-flop synchronizers and debounced stable levels
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      syncA <= '0;
      syncB <= '0;
      level <= '0;
    end else begin
      syncA <= rawKeys;
      syncB <= syncA;
      level <= levelNextC;
    end
  end

  for (genvar i = 0; i < NumKeys; i++) begin : gDebounce
    logic [DbW-1:0] dbCnt;
    logic           differC;
    logic           doneC;

    assign differC       = syncB[i] ^ level[i];
    assign doneC         = differC && (dbCnt == DbW'(DEBOUNCE_CYCLES));
    assign riseC[i]      = doneC & ~level[i];
    assign levelNextC[i] = level[i] ^ doneC;

    // Any cycle that agrees with the stable level restarts the count
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        dbCnt <= '0;
      end else if (!differC || doneC) begin
        dbCnt <= '0;
      end else begin
        dbCnt <= dbCnt + DbW'(1);
      end
    end
  end

  for (genvar d = 0; d < NumDirs; d++) begin : gRepeat
    localparam int KeyIdx = d + 2;

    repState_t       state;
    repState_t       stateNext;
    logic [RepW-1:0] repCnt;
    logic [RepW-1:0] repCntNext;
    logic            pulseC;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state  <= IDLE;
        repCnt <= '0;
      end else begin
        state  <= stateNext;
        repCnt <= repCntNext;
      end
    end

    // A release always wins over a repeat pulse due on the same edge
    always_comb begin
      stateNext  = state;
      repCntNext = repCnt;
      pulseC     = 1'b0;
      case (state)
        IDLE: begin
          if (riseC[KeyIdx]) begin
            stateNext  = DELAY;
            repCntNext = RepW'(REPEAT_DELAY - 1);
            pulseC     = 1'b1;
          end
        end
        DELAY, REPEAT: begin
          if (!levelNextC[KeyIdx]) begin
            stateNext  = IDLE;
            repCntNext = '0;
          end else if (repCnt == '0) begin
            stateNext  = REPEAT;
            repCntNext = RepW'(REPEAT_PERIOD - 1);
            pulseC     = 1'b1;
          end else begin
            repCntNext = repCnt - RepW'(1);
          end
        end
        default: begin
          stateNext  = IDLE;
          repCntNext = '0;
        end
      endcase
    end

    assign dirPulseC[d] = pulseC;
  end

  assign upDownBlockC    = levelNextC[2] & levelNextC[3];
  assign leftRightBlockC = levelNextC[4] & levelNextC[5];

  // Pulse outputs; opposing pairs are muted while both keys are held
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      enter <= 1'b0;
      pause <= 1'b0;
      up    <= 1'b0;
      down  <= 1'b0;
      left  <= 1'b0;
      right <= 1'b0;
    end else begin
      enter <= riseC[0];
      pause <= riseC[1];
      up    <= dirPulseC[0] & ~upDownBlockC;
      down  <= dirPulseC[1] & ~upDownBlockC;
      left  <= dirPulseC[2] & ~leftRightBlockC;
      right <= dirPulseC[3] & ~leftRightBlockC;
    end
  end

  assign key_level = level;

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner: expected pulse edges are queued as stimulus is
// applied and every cycle's pulse vector is compared against the queue.
module tb_key_conditioner;

  localparam int DEB  = 4;
  localparam int RDLY = 10;
  localparam int RPER = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btnEnter = 1'b0, btnPause = 1'b0, btnUp = 1'b0;
  logic       btnDown = 1'b0, btnLeft = 1'b0, btnRight = 1'b0;
  logic       enter, pause, up, down, left, right;
  logic [5:0] key_level;

  typedef struct {
    int         edgeNum;
    logic [5:0] pulses;
  } expT;

  expT expQ[$];
  int  edgeCnt = 0;
  int  base = 0;
  int  nChecks = 0;
  int  nPass = 0;
  bit  monOn = 1'b0;

  key_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY(RDLY),
    .REPEAT_PERIOD(RPER)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_enter(btnEnter), .btn_pause(btnPause), .btn_up(btnUp),
    .btn_down(btnDown), .btn_left(btnLeft), .btn_right(btnRight),
    .enter(enter), .pause(pause), .up(up), .down(down), .left(left), .right(right),
    .key_level(key_level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edgeCnt <= edgeCnt + 1;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s at edge %0d: got %0h expected %0h", tag, edgeCnt, got, exp);
  endtask

  // Every cycle: pulse vector must equal the OR of all entries due on this edge
  always @(negedge clk) begin
    logic [5:0] expV;
    if (monOn) begin
      expV = '0;
      for (int i = expQ.size() - 1; i >= 0; i--) begin
        if (expQ[i].edgeNum == edgeCnt) begin
          expV |= expQ[i].pulses;
          expQ.delete(i);
        end
      end
      checkVal("pulses", 32'({right, left, down, up, pause, enter}), 32'(expV));
    end
  end

  task automatic startScen();
    @(negedge clk);
    base = edgeCnt;
  endtask

  task automatic goTo(input int e);
    while (edgeCnt < base + 1 + e) @(negedge clk);
  endtask

  task automatic pushExp(input int e, input logic [5:0] v);
    expT t;
    t.edgeNum = base + 1 + e;
    t.pulses  = v;
    expQ.push_back(t);
  endtask

  // Direction schedule: press at k, pulses strictly before stopE, masked window skipped
  task automatic pushDir(input int bitIdx, input int k, input int stopE,
                         input int maskLo, input int maskHi);
    logic [5:0] v;
    int         p;
    v = 6'b000001 << bitIdx;
    p = k + DEB + 2;
    if (p < stopE && !(p >= maskLo && p <= maskHi)) pushExp(p, v);
    p = k + DEB + 2 + RDLY;
    while (p < stopE) begin
      if (!(p >= maskLo && p <= maskHi)) pushExp(p, v);
      p += RPER;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    monOn = 1'b1;
    checkVal("rst_level", 32'(key_level), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single press of enter, held 50 cycles
    startScen();
    btnEnter = 1'b1;
    pushExp(DEB + 2, 6'b000001);
    goTo(DEB + 1);
    checkVal("enter_lvl_pre", 32'(key_level[0]), 32'd0);
    goTo(DEB + 2);
    checkVal("enter_lvl", 32'(key_level[0]), 32'd1);
    goTo(49);
    btnEnter = 1'b0;
    goTo(55);
    checkVal("enter_rel_pre", 32'(key_level[0]), 32'd1);
    goTo(56);
    checkVal("enter_rel", 32'(key_level[0]), 32'd0);
    goTo(60);

    // Bouncing pause never settles
    startScen();
    for (int c = 0; c < 20; c++) begin
      btnPause = ((c % 4) < 2);
      goTo(c);
      checkVal("pause_lvl", 32'(key_level[1]), 32'd0);
    end
    btnPause = 1'b0;
    goTo(30);

    // Up held 40 cycles; release lands exactly on a due repeat
    startScen();
    btnUp = 1'b1;
    pushDir(2, 0, 40 + DEB + 2, 0, -1);
    goTo(39);
    btnUp = 1'b0;
    goTo(45);
    checkVal("up_lvl_held", 32'(key_level[2]), 32'd1);
    goTo(46);
    checkVal("up_lvl_rel", 32'(key_level[2]), 32'd0);
    goTo(52);

    // Left held, right overlaps: both muted during overlap
    startScen();
    btnLeft = 1'b1;
    pushDir(4, 0, 50 + DEB + 2, 26, 35);
    pushDir(5, 20, 30 + DEB + 2, 26, 35);
    goTo(19);
    btnRight = 1'b1;
    goTo(29);
    btnRight = 1'b0;
    goTo(30);
    checkVal("overlap_lvl", 32'(key_level), 32'h30);
    goTo(49);
    btnLeft = 1'b0;
    goTo(56);
    checkVal("lr_rel_lvl", 32'(key_level), 32'd0);
    goTo(62);

    // Down held through a two-cycle reset
    startScen();
    btnDown = 1'b1;
    pushDir(3, 0, 12, 0, -1);
    goTo(11);
    rst_n = 1'b0;
    goTo(12);
    checkVal("rst_mid_lvl", 32'(key_level), 32'd0);
    goTo(13);
    rst_n = 1'b1;
    checkVal("rst_mid_lvl2", 32'(key_level), 32'd0);
    pushDir(3, 14, 40 + DEB + 2, 0, -1);
    goTo(19);
    checkVal("down_lvl_pre", 32'(key_level[3]), 32'd0);
    goTo(20);
    checkVal("down_lvl", 32'(key_level[3]), 32'd1);
    goTo(39);
    btnDown = 1'b0;
    goTo(52);

    // Enter and up pressed together
    startScen();
    btnEnter = 1'b1;
    btnUp    = 1'b1;
    pushExp(DEB + 2, 6'b000101);
    pushExp(DEB + 2 + RDLY, 6'b000100);
    goTo(DEB + 2);
    checkVal("dual_lvl", 32'(key_level), 32'h05);
    goTo(11);
    btnEnter = 1'b0;
    btnUp    = 1'b0;
    goTo(24);

    checkVal("queue_drained", 32'(expQ.size()), 32'd0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
